// File: rtl/multi_lane_instr_queue_pkg.sv
// Shared widths and helpers for the multi-lane instruction queue.
package iq_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned MAX_LANES = 4;

    // Pointer width: slot index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Number of contiguous set bits starting at bit 0.
    function automatic int unsigned prefix_run(input logic [MAX_LANES-1:0] vec);
        int unsigned n;
        logic        stop;
        n    = 0;
        stop = 1'b0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (!vec[i]) stop = 1'b1;
            if (!stop) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_lane_instr_queue_if.sv
// Enqueue/dequeue handshake bundle between front end, queue and dispatch.
interface multi_lane_instr_queue_if
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned INSTR_WIDTH = INSTR_W,
    parameter int unsigned PC_WIDTH    = PC_W,
    parameter int unsigned LANES       = 2
);
    logic [LANES-1:0]             enq_valid;
    logic [LANES*INSTR_WIDTH-1:0] enq_instr;
    logic [LANES*PC_WIDTH-1:0]    enq_pc;
    logic                         enq_ready;
    logic [LANES-1:0]             deq_valid;
    logic [LANES*INSTR_WIDTH-1:0] deq_instr;
    logic [LANES*PC_WIDTH-1:0]    deq_pc;
    logic [LANES-1:0]             deq_ready;
    logic [$clog2(DEPTH):0]       count;
    logic                         full;
    logic                         empty;

    modport master (
        output enq_valid, enq_instr, enq_pc, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, count, full, empty
    );

    modport slave (
        input  enq_valid, enq_instr, enq_pc, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, count, full, empty
    );
endinterface

// File: rtl/multi_lane_instr_queue_lane_prefix_count.sv
// Leading-ones counter over a LANES-bit lane vector.
module lane_prefix_count
    import iq_pkg::*;
#(
    parameter int unsigned LANES = 2,
    localparam int unsigned CW   = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] vec,
    output logic [CW-1:0]    run
);
    // Run length from lane 0; a gap ends the run.
    always_comb begin
        run = CW'(prefix_run(MAX_LANES'(vec)));
    end
endmodule

// File: rtl/multi_lane_instr_queue.sv
// Multi-lane FWFT instruction queue: circular buffer with wrap-bit pointers.
module multi_lane_instr_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned INSTR_WIDTH = INSTR_W,
    parameter int unsigned PC_WIDTH    = PC_W,
    parameter int unsigned LANES       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    multi_lane_instr_queue_if.slave    q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(LANES + 1);

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];

    logic [PW-1:0]    head, tail, count;
    logic             enq_rdy;
    logic [LANES-1:0] dv, deq_take;
    logic [CW-1:0]    n_enq, n_deq;

    assign count   = tail - head;
    assign enq_rdy = (count <= PW'(DEPTH - LANES));

    assign q.count     = count;
    assign q.full      = (count == PW'(DEPTH));
    assign q.empty     = (count == '0);
    assign q.enq_ready = enq_rdy;
    assign q.deq_valid = dv;
    assign deq_take    = dv & q.deq_ready;

    lane_prefix_count #(.LANES(LANES)) u_enq_run (.vec(q.enq_valid), .run(n_enq));
    lane_prefix_count #(.LANES(LANES)) u_deq_run (.vec(deq_take),    .run(n_deq));

    // Combinational head-window read; invalid lanes are forced to zero.
    always_comb begin
        dv          = '0;
        q.deq_instr = '0;
        q.deq_pc    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            dv[i] = (count > PW'(i));
            if (dv[i]) begin
                q.deq_instr[i*INSTR_WIDTH +: INSTR_WIDTH] = instr_mem[AW'(head + PW'(i))];
                q.deq_pc[i*PC_WIDTH +: PC_WIDTH]          = pc_mem[AW'(head + PW'(i))];
            end
        end
    end

    // Pointer update; flush wins over both enqueue and dequeue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_rdy) tail <= tail + PW'(n_enq);
            head <= head + PW'(n_deq);
        end
    end

    // Per-lane storage write at tail+i for the accepted prefix of lanes.
    always_ff @(posedge clk) begin
        if (!flush && enq_rdy) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (CW'(i) < n_enq) begin
                    instr_mem[AW'(tail + PW'(i))] <= q.enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
                    pc_mem[AW'(tail + PW'(i))]    <= q.enq_pc[i*PC_WIDTH +: PC_WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_lane_instr_queue.sv
// Directed self-checking bench for multi_lane_instr_queue (DEPTH=8, LANES=2).
module tb_multi_lane_instr_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LANES = 2;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    multi_lane_instr_queue_if #(
        .DEPTH(DEPTH), .INSTR_WIDTH(32), .PC_WIDTH(32), .LANES(LANES)
    ) qi ();

    multi_lane_instr_queue #(
        .DEPTH(DEPTH), .INSTR_WIDTH(32), .PC_WIDTH(32), .LANES(LANES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .q(qi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive both lanes; PC is instr + 0x1000 so it can be predicted.
    task automatic drive(input logic [1:0] ev, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] dr);
        qi.enq_valid = ev;
        qi.enq_instr = {i1, i0};
        qi.enq_pc    = {i1 + 32'h1000, i0 + 32'h1000};
        qi.deq_ready = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        drive(2'b00, 0, 0, 2'b00);
        #12;
        chk("reset_count", 64'(qi.count), 0);
        chk("reset_empty", 64'(qi.empty), 1);
        chk("reset_full", 64'(qi.full), 0);
        chk("reset_enq_ready", 64'(qi.enq_ready), 1);
        chk("reset_deq_valid", 64'(qi.deq_valid), 0);
        reset = 1'b0;

        // Fill 4 x 2 entries
        drive(2'b11, 32'h100, 32'h101, 2'b00); tick();
        chk("fill1_count", 64'(qi.count), 2);
        chk("fill1_deq_valid", 64'(qi.deq_valid), 2'b11);
        chk("fill1_lane0", 64'(qi.deq_instr[31:0]), 32'h100);
        chk("fill1_lane1", 64'(qi.deq_instr[63:32]), 32'h101);
        chk("fill1_pc0", 64'(qi.deq_pc[31:0]), 32'h1100);
        drive(2'b11, 32'h102, 32'h103, 2'b00); tick();
        chk("fill2_count", 64'(qi.count), 4);
        drive(2'b11, 32'h104, 32'h105, 2'b00); tick();
        chk("fill3_count", 64'(qi.count), 6);
        chk("fill3_enq_ready", 64'(qi.enq_ready), 1);
        drive(2'b11, 32'h106, 32'h107, 2'b00); tick();
        chk("fill4_count", 64'(qi.count), 8);
        chk("fill4_full", 64'(qi.full), 1);
        chk("fill4_enq_ready", 64'(qi.enq_ready), 0);

        // Fifth write is ignored
        drive(2'b11, 32'h1FE, 32'h1FF, 2'b00); tick();
        chk("over_count", 64'(qi.count), 8);
        chk("over_lane0", 64'(qi.deq_instr[31:0]), 32'h100);

        // Drain to count 5
        drive(2'b00, 0, 0, 2'b11); tick();
        chk("drain1_count", 64'(qi.count), 6);
        chk("drain1_lane0", 64'(qi.deq_instr[31:0]), 32'h102);
        drive(2'b00, 0, 0, 2'b01); tick();
        chk("drain2_count", 64'(qi.count), 5);
        chk("drain2_lane1", 64'(qi.deq_instr[63:32]), 32'h104);

        // Mixed: enqueue 1 and dequeue 2 in the same cycle
        drive(2'b01, 32'h108, 32'h0, 2'b11); tick();
        chk("mixed_count", 64'(qi.count), 4);
        chk("mixed_lane0", 64'(qi.deq_instr[31:0]), 32'h105);
        chk("mixed_lane1", 64'(qi.deq_instr[63:32]), 32'h106);

        // Gap in enq_valid: nothing written
        drive(2'b10, 32'h0, 32'h1AA, 2'b00); tick();
        chk("enq_gap_count", 64'(qi.count), 4);

        // Dequeue gap
        drive(2'b00, 0, 0, 2'b01); tick();
        chk("to3_count", 64'(qi.count), 3);
        chk("to3_lane0", 64'(qi.deq_instr[31:0]), 32'h106);
        drive(2'b00, 0, 0, 2'b10); tick();
        chk("deq_gap_count", 64'(qi.count), 3);
        chk("deq_gap_lane0", 64'(qi.deq_instr[31:0]), 32'h106);
        drive(2'b00, 0, 0, 2'b01); tick();
        chk("deq1_count", 64'(qi.count), 2);
        chk("deq1_lane0", 64'(qi.deq_instr[31:0]), 32'h107);
        chk("deq1_lane1", 64'(qi.deq_instr[63:32]), 32'h108);
        chk("deq1_pc0", 64'(qi.deq_pc[31:0]), 32'h1107);

        // Grow to 6, then flush with a simultaneous write
        drive(2'b11, 32'h109, 32'h10A, 2'b00); tick();
        drive(2'b11, 32'h10B, 32'h10C, 2'b00); tick();
        chk("pre_flush_count", 64'(qi.count), 6);
        flush = 1'b1;
        drive(2'b11, 32'h1EE, 32'h1EF, 2'b00); tick();
        flush = 1'b0;
        chk("flush_count", 64'(qi.count), 0);
        chk("flush_empty", 64'(qi.empty), 1);
        chk("flush_deq_valid", 64'(qi.deq_valid), 0);

        // Walk head to slot 7 with the queue empty
        drive(2'b11, 0, 0, 2'b00); tick();
        drive(2'b11, 0, 0, 2'b11); tick();
        drive(2'b11, 0, 0, 2'b11); tick();
        drive(2'b01, 0, 0, 2'b11); tick();
        chk("one_count", 64'(qi.count), 1);
        chk("one_deq_valid", 64'(qi.deq_valid), 2'b01);
        drive(2'b00, 0, 0, 2'b01); tick();
        chk("walk_empty", 64'(qi.empty), 1);
        chk("walk_deq_valid", 64'(qi.deq_valid), 0);

        // Wrap: two-lane write across slot 7 -> 0
        drive(2'b11, 32'h200, 32'h201, 2'b00); tick();
        chk("wrap_count", 64'(qi.count), 2);
        chk("wrap_lane0", 64'(qi.deq_instr[31:0]), 32'h200);
        chk("wrap_lane1", 64'(qi.deq_instr[63:32]), 32'h201);

        // count 7: enq_ready low even while dequeuing
        drive(2'b11, 32'h300, 32'h301, 2'b00); tick();
        drive(2'b11, 32'h302, 32'h303, 2'b00); tick();
        drive(2'b01, 32'h304, 32'h0, 2'b00); tick();
        chk("c7_count", 64'(qi.count), 7);
        chk("c7_enq_ready", 64'(qi.enq_ready), 0);
        chk("c7_full", 64'(qi.full), 0);
        drive(2'b11, 32'h3EE, 32'h3EF, 2'b11); tick();
        chk("c7_deq_count", 64'(qi.count), 5);
        chk("c7_deq_lane0", 64'(qi.deq_instr[31:0]), 32'h300);
        chk("c7_deq_lane1", 64'(qi.deq_instr[63:32]), 32'h301);

        // Asynchronous reset mid-cycle with traffic pending
        drive(2'b11, 32'h400, 32'h401, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count", 64'(qi.count), 0);
        chk("areset_empty", 64'(qi.empty), 1);
        chk("areset_full", 64'(qi.full), 0);
        chk("areset_enq_ready", 64'(qi.enq_ready), 1);
        chk("areset_deq_valid", 64'(qi.deq_valid), 0);
        tick();
        reset = 1'b0;
        drive(2'b00, 0, 0, 2'b00);
        tick();
        chk("post_reset_count", 64'(qi.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
